// File: rtl/scc_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : scc_fetch_queue
// Description : Sequential instruction fetch into a DEPTH-entry {instr, pc}
//               FIFO, with branch redirect/flush and halt.
// Revision    : 1.0 - initial release
// ============================================================================
module scc_fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 1
) (
    input  logic                         clk,
    input  logic                         reset_s,
    input  logic                         halt,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic                         mem_en,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [INSTR_W-1:0]           mem_data,
    output logic                         instr_valid,
    output logic [INSTR_W-1:0]           instr_out,
    output logic [ADDR_W-1:0]            instr_pc,
    input  logic                         instr_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int                  c_ptr_w   = $clog2(DEPTH);
    localparam int                  c_cnt_w   = $clog2(DEPTH+1);
    localparam logic [ADDR_W-1:0]   c_pc_step = ADDR_W'(PC_STEP);
    localparam logic [c_cnt_w:0]    c_depth   = (c_cnt_w+1)'(DEPTH);

    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_inflight_pc;
    logic               r_inflight;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [INSTR_W-1:0] r_instr_mem [DEPTH];
    logic [ADDR_W-1:0]  r_pc_mem    [DEPTH];

    logic               w_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_issue;
    logic [c_cnt_w:0]   w_occupancy;

    assign w_valid = ~reset_s & (r_count != '0);
    assign w_pop   = w_valid & instr_ready;
    assign w_push  = ~reset_s & ~redirect & r_inflight;

    // Entries held plus the response still in flight, minus this cycle's pop:
    // issuing only below DEPTH guarantees every response has a free slot.
    assign w_occupancy = {1'b0, r_count}
                       + {{c_cnt_w{1'b0}}, r_inflight}
                       - {{c_cnt_w{1'b0}}, w_pop};
    assign w_issue     = ~reset_s & ~halt & ~redirect & (w_occupancy < c_depth);

    assign mem_en      = w_issue;
    assign mem_addr    = r_fetch_pc;
    assign instr_valid = w_valid;
    assign instr_out   = r_instr_mem[r_rd_ptr];
    assign instr_pc    = r_pc_mem[r_rd_ptr];
    assign level       = reset_s ? '0 : r_count;

    always_ff @(posedge clk) begin
        if (reset_s) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= RESET_PC;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc;
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_issue) begin
                r_fetch_pc    <= r_fetch_pc + c_pc_step;
                r_inflight    <= 1'b1;
                r_inflight_pc <= r_fetch_pc;
            end else begin
                r_inflight    <= 1'b0;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

    // Storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= mem_data;
            r_pc_mem[r_wr_ptr]    <= r_inflight_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scc_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_scc_fetch_queue
// Description : Self-checking bench for scc_fetch_queue: cycle vector table,
//               in-order scoreboard, halt and PC-wrap sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scc_fetch_queue;

    typedef struct {
        logic        rst;
        logic        halt;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        chk_addr;
        logic        exp_en;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [2:0]  exp_level;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_s = 1'b1;
    logic        halt = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_data = '0;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b1;
    logic [2:0]  level;

    logic        rst8 = 1'b1;
    logic        mem_en8;
    logic [7:0]  mem_addr8;
    logic [31:0] mem_data8 = '0;
    logic        instr_valid8;
    logic [31:0] instr_out8;
    logic [7:0]  instr_pc8;
    logic [2:0]  level8;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sb[$];
    logic [31:0] m_pc = '0;
    vec_t        vecs[$];

    always #5 clk = ~clk;

    scc_fetch_queue #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(1)) dut (
        .clk(clk), .reset_s(reset_s), .halt(halt), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
        .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .level(level));

    scc_fetch_queue #(.ADDR_W(8), .INSTR_W(32), .DEPTH(4), .RESET_PC(8'hFF), .PC_STEP(1)) dut8 (
        .clk(clk), .reset_s(rst8), .halt(1'b0), .redirect(1'b0), .redirect_pc(8'h00),
        .mem_en(mem_en8), .mem_addr(mem_addr8), .mem_data(mem_data8),
        .instr_valid(instr_valid8), .instr_out(instr_out8), .instr_pc(instr_pc8),
        .instr_ready(1'b1), .level(level8));

    // Synchronous instruction memory, one-cycle latency, word = addr + 0x1000
    always @(posedge clk) begin
        if (mem_en)  mem_data  <= mem_addr + 32'h1000;
        if (mem_en8) mem_data8 <= {24'h0, mem_addr8} + 32'h1000;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic hlt, input logic rdr, input logic [31:0] rpc,
                       input logic rdy, input logic ca, input logic en, input logic [31:0] a,
                       input logic v, input logic [31:0] pc, input logic [2:0] l);
        vec_t r;
        r.rst = rst; r.halt = hlt; r.redir = rdr; r.rpc = rpc; r.ready = rdy; r.chk_addr = ca;
        r.exp_en = en; r.exp_addr = a; r.exp_valid = v; r.exp_pc = pc; r.exp_level = l;
        vecs.push_back(r);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each issue pushes its address; each pop must match the oldest.
    always @(negedge clk) begin
        if (reset_s) begin
            sb.delete();
            m_pc = 32'h0;
        end else begin
            if (instr_valid && instr_ready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_pop: got pc %h, expected no entry", instr_pc);
                end else begin
                    logic [31:0] e;
                    e = sb.pop_front();
                    if (instr_pc !== e || instr_out !== e + 32'h1000) begin
                        n_fail++;
                        $display("FAIL sb_pop: got pc %h instr %h, expected pc %h instr %h",
                                 instr_pc, instr_out, e, e + 32'h1000);
                    end
                end
            end
            if (redirect) begin
                sb.delete();
                m_pc = redirect_pc;
            end else if (mem_en) begin
                chk("sb_issue_addr", mem_addr, m_pc);
                sb.push_back(m_pc);
                m_pc = m_pc + 32'h1;
            end
        end
    end

    initial begin
        // rst hlt rdr rpc   rdy ca en addr  v  pc  lvl
        add(1, 0, 0, 0,     1,  0, 0, 0,    0, 0,  0);
        add(1, 0, 0, 0,     1,  1, 0, 0,    0, 0,  0);
        add(0, 0, 0, 0,     1,  1, 1, 0,    0, 0,  0);
        add(0, 0, 0, 0,     1,  1, 1, 1,    0, 0,  0);
        add(0, 0, 0, 0,     1,  1, 1, 2,    1, 0,  1);
        add(0, 0, 0, 0,     1,  1, 1, 3,    1, 1,  1);
        add(0, 0, 0, 0,     1,  1, 1, 4,    1, 2,  1);
        add(0, 0, 1, 'h40,  1,  1, 0, 5,    1, 3,  1);
        add(0, 0, 0, 0,     1,  1, 1, 'h40, 0, 0,  0);
        add(0, 0, 0, 0,     1,  1, 1, 'h41, 0, 0,  0);
        add(0, 0, 0, 0,     1,  1, 1, 'h42, 1, 'h40, 1);
        add(0, 0, 0, 0,     1,  1, 1, 'h43, 1, 'h41, 1);
        // backpressure, then release, then reset with a response in flight
        add(1, 0, 0, 0,     0,  0, 0, 0,    0, 0,  0);
        add(0, 0, 0, 0,     0,  1, 1, 0,    0, 0,  0);
        add(0, 0, 0, 0,     0,  1, 1, 1,    0, 0,  0);
        add(0, 0, 0, 0,     0,  1, 1, 2,    1, 0,  1);
        add(0, 0, 0, 0,     0,  1, 1, 3,    1, 0,  2);
        add(0, 0, 0, 0,     0,  1, 0, 4,    1, 0,  3);
        add(0, 0, 0, 0,     0,  1, 0, 4,    1, 0,  4);
        add(0, 0, 0, 0,     1,  1, 1, 4,    1, 0,  4);
        add(0, 0, 0, 0,     1,  1, 1, 5,    1, 1,  3);
        add(0, 0, 0, 0,     1,  1, 1, 6,    1, 2,  3);
        add(0, 0, 0, 0,     1,  1, 1, 7,    1, 3,  3);
        add(0, 0, 0, 0,     1,  1, 1, 8,    1, 4,  3);
        add(0, 0, 0, 0,     0,  1, 0, 9,    1, 5,  3);
        add(1, 0, 0, 0,     0,  0, 0, 0,    0, 0,  0);
        add(0, 0, 0, 0,     1,  1, 1, 0,    0, 0,  0);
        add(0, 0, 0, 0,     1,  1, 1, 1,    0, 0,  0);
        add(0, 0, 0, 0,     1,  1, 1, 2,    1, 0,  1);

        foreach (vecs[i]) begin
            reset_s     = vecs[i].rst;
            halt        = vecs[i].halt;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            instr_ready = vecs[i].ready;
            @(negedge clk);
            chk($sformatf("v%0d_mem_en", i), {31'h0, mem_en}, {31'h0, vecs[i].exp_en});
            if (vecs[i].chk_addr) chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].exp_valid});
            chk($sformatf("v%0d_level", i), {29'h0, level}, {29'h0, vecs[i].exp_level});
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d_pc", i), instr_pc, vecs[i].exp_pc);
                chk($sformatf("v%0d_instr", i), instr_out, vecs[i].exp_pc + 32'h1000);
            end
            step();
        end

        // Halt the cycle after the issue of address 7, with a response in flight
        reset_s = 1'b1; redirect = 1'b0; halt = 1'b0; instr_ready = 1'b1;
        step();
        reset_s = 1'b0;
        repeat (8) step();
        halt = 1'b1; instr_ready = 1'b0;
        @(negedge clk);
        chk("halt_c8_level", {29'h0, level}, 32'd1);
        chk("halt_c8_mem_en", {31'h0, mem_en}, 32'd0);
        step();
        @(negedge clk);
        chk("halt_c9_level", {29'h0, level}, 32'd2);
        chk("halt_c9_mem_en", {31'h0, mem_en}, 32'd0);
        chk("halt_c9_mem_addr", mem_addr, 32'd8);
        step();
        @(negedge clk);
        chk("halt_c10_mem_en", {31'h0, mem_en}, 32'd0);
        chk("halt_c10_level", {29'h0, level}, 32'd2);
        step();
        halt = 1'b0;
        @(negedge clk);
        chk("resume_mem_en", {31'h0, mem_en}, 32'd1);
        chk("resume_mem_addr", mem_addr, 32'd8);
        step();
        instr_ready = 1'b1;
        repeat (8) step();

        // 8-bit PC wraps from 0xFF to 0x00
        rst8 = 1'b1;
        step();
        rst8 = 1'b0;
        @(negedge clk);
        chk("wrap_c0_addr", {24'h0, mem_addr8}, 32'hFF);
        chk("wrap_c0_en", {31'h0, mem_en8}, 32'd1);
        step();
        @(negedge clk);
        chk("wrap_c1_addr", {24'h0, mem_addr8}, 32'h00);
        step();
        for (int k = 0; k < 3; k++) begin
            logic [7:0] ep;
            ep = 8'hFF + 8'(k);
            @(negedge clk);
            chk($sformatf("wrap_c%0d_valid", k + 2), {31'h0, instr_valid8}, 32'd1);
            chk($sformatf("wrap_c%0d_pc", k + 2), {24'h0, instr_pc8}, {24'h0, ep});
            chk($sformatf("wrap_c%0d_instr", k + 2), instr_out8, {24'h0, ep} + 32'h1000);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
